// File: rtl/riot_bus_pkg.sv
// Shared definitions for the RIOT bus master: FSM state encoding and
// RIOT register addresses.
// Optional feature macro: RIOT_MASTER_POLL_EN (adds the GAP state).
package riot_bus_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StIssue = 3'd1,
      StWait  = 3'd2,
`ifdef RIOT_MASTER_POLL_EN
      StGap   = 3'd3,
`endif
      StResp  = 3'd4
   } state_e;

   localparam logic [6:0] SWCHA  = 7'h00;
   localparam logic [6:0] SWACNT = 7'h01;
   localparam logic [6:0] SWCHB  = 7'h02;
   localparam logic [6:0] SWBCNT = 7'h03;
   localparam logic [6:0] INTIM  = 7'h04;
   localparam logic [6:0] INSTAT = 7'h05;
   localparam logic [6:0] TIM1T  = 7'h14;
   localparam logic [6:0] TIM8T  = 7'h15;
   localparam logic [6:0] TIM64T = 7'h16;
   localparam logic [6:0] T1024T = 7'h17;

endpackage

// File: rtl/riot_bus_master.sv
// Single-outstanding bus master toward a RIOT peripheral. Accepts one
// command at a time, issues a one-cycle strobe, waits RD_LATENCY cycles for
// read data and holds the response until consumed.
// Optional feature macro: RIOT_MASTER_POLL_EN (poll reads with a mask,
// repeated with POLL_GAP idle cycles until a masked bit is set).
module riot_bus_master
   import riot_bus_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned POLL_GAP   = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_we_i,
   input  logic [6:0] cmd_adr_i,
   input  logic [7:0] cmd_dat_i,
`ifdef RIOT_MASTER_POLL_EN
   input  logic       cmd_poll_i,
`endif
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_dat_o,
   output logic       stb_o,
   output logic       we_o,
   output logic [6:0] adr_o,
   output logic [7:0] dat_o,
   input  logic [7:0] dat_i,
   output logic       busy_o
);

   // WAIT counts down from RD_LATENCY-1; the last WAIT cycle has count 0.
   localparam logic [2:0] WaitInit = 3'(RD_LATENCY - 1);

   state_e     state_q, state_d;
   logic [2:0] wait_q, wait_d;
   logic       we_q;
   logic [6:0] adr_q;
   logic [7:0] dat_q;
   logic [7:0] rsp_dat_q;
   logic       accept;
   logic       sample_en;

`ifdef RIOT_MASTER_POLL_EN
   localparam logic [7:0] GapInit = 8'(POLL_GAP - 1);
   logic [7:0] gap_q, gap_d;
   logic       poll_q;
   logic       poll_again;

   // dat_q doubles as the poll mask; a zero mask never retries.
   assign poll_again = poll_q && (dat_q != 8'h00) && ((dat_i & dat_q) == 8'h00);
`endif

   assign cmd_ready_o = (state_q == StIdle) && !rsp_valid_o;
   assign accept      = cmd_valid_i && cmd_ready_o;
   assign sample_en   = (state_q == StWait) && (wait_q == 3'd0);

   assign stb_o       = (state_q == StIssue);
   assign we_o        = stb_o && we_q;
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
   assign rsp_valid_o = (state_q == StResp);
   assign rsp_dat_o   = rsp_dat_q;
   assign busy_o      = (state_q != StIdle);

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
`ifdef RIOT_MASTER_POLL_EN
      gap_d   = gap_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StIssue;
         end
         StIssue: begin
            if (we_q) begin
               state_d = StIdle;
            end else begin
               state_d = StWait;
               wait_d  = WaitInit;
            end
         end
         StWait: begin
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else begin
               state_d = StResp;
`ifdef RIOT_MASTER_POLL_EN
               if (poll_again) begin
                  if (POLL_GAP == 0) begin
                     state_d = StIssue;
                  end else begin
                     state_d = StGap;
                     gap_d   = GapInit;
                  end
               end
`endif
            end
         end
`ifdef RIOT_MASTER_POLL_EN
         StGap: begin
            if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
            else               state_d = StIssue;
         end
`endif
         StResp: begin
            if (rsp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         wait_q  <= 3'd0;
`ifdef RIOT_MASTER_POLL_EN
         gap_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
`ifdef RIOT_MASTER_POLL_EN
         gap_q   <= gap_d;
`endif
      end
   end

   // Command capture on acceptance and read-data sampling.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q      <= 1'b0;
         adr_q     <= 7'h00;
         dat_q     <= 8'h00;
         rsp_dat_q <= 8'h00;
`ifdef RIOT_MASTER_POLL_EN
         poll_q    <= 1'b0;
`endif
      end else begin
         if (accept) begin
            we_q  <= cmd_we_i;
            adr_q <= cmd_adr_i;
            dat_q <= cmd_dat_i;
`ifdef RIOT_MASTER_POLL_EN
            poll_q <= cmd_poll_i && !cmd_we_i;
`endif
         end
         if (sample_en) rsp_dat_q <= dat_i;
      end
   end

endmodule

// File: tb/tb_riot_bus_master.sv
// Directed self-checking bench for riot_bus_master (RD_LATENCY=1, POLL_GAP=4).
// Poll scenarios run only when RIOT_MASTER_POLL_EN is defined.
module tb_riot_bus_master;
   import riot_bus_pkg::*;

   logic       clk_i;
   logic       rst_ni;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic       cmd_we_i;
   logic [6:0] cmd_adr_i;
   logic [7:0] cmd_dat_i;
`ifdef RIOT_MASTER_POLL_EN
   logic       cmd_poll_i;
`endif
   logic       rsp_valid_o;
   logic       rsp_ready_i;
   logic [7:0] rsp_dat_o;
   logic       stb_o;
   logic       we_o;
   logic [6:0] adr_o;
   logic [7:0] dat_o;
   logic [7:0] dat_i;
   logic       busy_o;

   int errors = 0;
   int checks = 0;

   // Peripheral model state.
   logic [7:0] rd_val;
   logic       poll_mode;
   int         poll_idx;
   int         cyc;
   int         stb_cnt;
   int         consec_stb;
   logic       prev_stb;
   int         acc_q[$];
   int         stb_q[$];

   riot_bus_master #(
      .RD_LATENCY(1),
      .POLL_GAP  (4)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_we_i   (cmd_we_i),
      .cmd_adr_i  (cmd_adr_i),
      .cmd_dat_i  (cmd_dat_i),
`ifdef RIOT_MASTER_POLL_EN
      .cmd_poll_i (cmd_poll_i),
`endif
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o  (rsp_dat_o),
      .stb_o      (stb_o),
      .we_o       (we_o),
      .adr_o      (adr_o),
      .dat_o      (dat_o),
      .dat_i      (dat_i),
      .busy_o     (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Poll model returns 0x00 for the first three reads, then 0xC0.
   assign dat_i = poll_mode ? ((poll_idx <= 3) ? 8'h00 : 8'hC0) : rd_val;

   // Bus monitor: counts strobes, acceptances and back-to-back strobes.
   initial begin
      cyc = 0; stb_cnt = 0; consec_stb = 0; prev_stb = 1'b0; poll_idx = 0;
   end
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      prev_stb <= stb_o;
      if (stb_o) begin
         stb_cnt <= stb_cnt + 1;
         stb_q.push_back(cyc);
      end
      if (stb_o && prev_stb) consec_stb <= consec_stb + 1;
      if (cmd_valid_i && cmd_ready_o) acc_q.push_back(cyc);
      if (!poll_mode)  poll_idx <= 0;
      else if (stb_o)  poll_idx <= poll_idx + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      int n;
      int base;
      rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = 7'h00;
      cmd_dat_i = 8'h00; rsp_ready_i = 1'b0; rd_val = 8'h00; poll_mode = 1'b0;
`ifdef RIOT_MASTER_POLL_EN
      cmd_poll_i = 1'b0;
`endif
      #1;
      check("rst_stb",       32'(stb_o),       32'd0);
      check("rst_we",        32'(we_o),        32'd0);
      check("rst_adr",       32'(adr_o),       32'd0);
      check("rst_dat",       32'(dat_o),       32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_dat",   32'(rsp_dat_o),   32'd0);
      check("rst_busy",      32'(busy_o),      32'd0);
      tick(3);
      rst_ni = 1'b1;
      tick(1);
      check("idle_ready", 32'(cmd_ready_o), 32'd1);

      // Write 0x20 to TIM64T.
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = TIM64T; cmd_dat_i = 8'h20;
      tick(1);
      cmd_valid_i = 1'b0;
      check("wr_stb",   32'(stb_o),       32'd1);
      check("wr_we",    32'(we_o),        32'd1);
      check("wr_adr",   32'(adr_o),       32'h16);
      check("wr_dat",   32'(dat_o),       32'h20);
      check("wr_busy",  32'(busy_o),      32'd1);
      check("wr_ready", 32'(cmd_ready_o), 32'd0);
      tick(1);
      check("wr_stb_end", 32'(stb_o),  32'd0);
      check("wr_we_idle", 32'(we_o),   32'd0);
      check("wr_adr_hold", 32'(adr_o), 32'h16);
      check("wr_dat_hold", 32'(dat_o), 32'h20);
      check("wr_idle",    32'(busy_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("wr_no_rsp", 32'(rsp_valid_o), 32'd0);
         tick(1);
      end
      check("wr_stb_count", 32'(stb_cnt), 32'd1);

      // Read SWCHB, model returns 0x3F.
      rd_val = 8'h3F;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = SWCHB; cmd_dat_i = 8'h00;
      tick(1);
      cmd_valid_i = 1'b0;
      check("rd_stb_t1",   32'(stb_o),       32'd1);
      check("rd_we",       32'(we_o),        32'd0);
      check("rd_adr",      32'(adr_o),       32'h02);
      check("rd_rsp_t1",   32'(rsp_valid_o), 32'd0);
      tick(1);
      check("rd_stb_t2",   32'(stb_o),       32'd0);
      check("rd_busy_t2",  32'(busy_o),      32'd1);
      check("rd_rsp_t2",   32'(rsp_valid_o), 32'd0);
      tick(1);
      check("rd_rsp_t3",   32'(rsp_valid_o), 32'd1);
      check("rd_dat_t3",   32'(rsp_dat_o),   32'h3F);

      // Backpressure for 10 cycles; a command offered meanwhile is dropped.
      rd_val = 8'h00;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = SWCHA; cmd_dat_i = 8'h55;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("hold_valid", 32'(rsp_valid_o), 32'd1);
         check("hold_dat",   32'(rsp_dat_o),   32'h3F);
         check("hold_ready", 32'(cmd_ready_o), 32'd0);
         check("hold_stb",   32'(stb_o),       32'd0);
      end
      rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
      tick(1);
      rsp_ready_i = 1'b0;
      check("rel_valid", 32'(rsp_valid_o), 32'd0);
      check("rel_busy",  32'(busy_o),      32'd0);
      check("rel_ready", 32'(cmd_ready_o), 32'd1);
      tick(3);
      check("no_queued_cmd", 32'(stb_cnt), 32'd2);

      // Reset during WAIT.
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = INTIM;
      tick(1);
      cmd_valid_i = 1'b0;
      check("rstw_issue", 32'(stb_o), 32'd1);
      tick(1);
      check("rstw_wait_busy", 32'(busy_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("rstw_stb",   32'(stb_o),       32'd0);
      check("rstw_busy",  32'(busy_o),      32'd0);
      check("rstw_rsp",   32'(rsp_valid_o), 32'd0);
      check("rstw_adr",   32'(adr_o),       32'd0);
      tick(2);
      rst_ni = 1'b1;
      tick(3);
      check("rstw_no_rsp", 32'(rsp_valid_o), 32'd0);

      // Reset during ISSUE drops the strobe immediately.
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = INSTAT;
      tick(1);
      cmd_valid_i = 1'b0;
      check("rsti_stb_pre", 32'(stb_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("rsti_stb",  32'(stb_o),  32'd0);
      check("rsti_busy", 32'(busy_o), 32'd0);
      tick(1);
      rst_ni = 1'b1;
      tick(1);

      // Normal command after reset release.
      check("post_rst_ready", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = TIM8T; cmd_dat_i = 8'hA5;
      tick(1);
      cmd_valid_i = 1'b0;
      check("post_rst_stb", 32'(stb_o), 32'd1);
      check("post_rst_adr", 32'(adr_o), 32'h15);
      check("post_rst_dat", 32'(dat_o), 32'hA5);
      tick(2);
      check("post_rst_count", 32'(stb_cnt), 32'd4);

      // Back-to-back writes with cmd_valid_i held high.
      acc_q.delete();
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = TIM1T; cmd_dat_i = 8'h01;
      tick(8);
      cmd_valid_i = 1'b0;
      tick(3);
      check("b2b_accepts", 32'(acc_q.size()), 32'd4);
      for (int i = 1; i < acc_q.size(); i++) begin
         check("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd2);
      end
      check("b2b_stb_count", 32'(stb_cnt), 32'd8);
      check("no_consec_stb", 32'(consec_stb), 32'd0);

`ifdef RIOT_MASTER_POLL_EN
      // Poll INSTAT with mask 0x80 until the model returns 0xC0.
      poll_mode = 1'b1;
      stb_q.delete();
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = INSTAT; cmd_dat_i = 8'h80;
      cmd_poll_i = 1'b1;
      tick(1);
      cmd_valid_i = 1'b0; cmd_poll_i = 1'b0;
      n = 0;
      while (!rsp_valid_o && n < 100) begin
         tick(1);
         n++;
      end
      check("poll_done", 32'(n < 100), 32'd1);
      check("poll_pulses", 32'(stb_q.size()), 32'd4);
      for (int i = 1; i < stb_q.size(); i++) begin
         check("poll_spacing", 32'(stb_q[i] - stb_q[i-1]), 32'd6);
      end
      check("poll_dat", 32'(rsp_dat_o), 32'hC0);
      rsp_ready_i = 1'b1;
      tick(1);
      rsp_ready_i = 1'b0;
      poll_mode = 1'b0;

      // Poll with a zero mask performs exactly one read.
      rd_val = 8'h00;
      base = stb_cnt;
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = INSTAT; cmd_dat_i = 8'h00;
      cmd_poll_i = 1'b1;
      tick(1);
      cmd_valid_i = 1'b0; cmd_poll_i = 1'b0;
      n = 0;
      while (!rsp_valid_o && n < 100) begin
         tick(1);
         n++;
      end
      check("poll0_done", 32'(n < 100), 32'd1);
      check("poll0_reads", 32'(stb_cnt - base), 32'd1);
      check("poll0_dat", 32'(rsp_dat_o), 32'h00);
      rsp_ready_i = 1'b1;
      tick(1);
      rsp_ready_i = 1'b0;
`endif

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
